// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider controller
//
// Purpose : FSM state encoding, default datapath width and the fixed result
//           constants used by div_seq_ctrl and div_sign_fix.
// Ports   : none (package).
package div_pkg;

  // Width of the combinational non-restoring divider array.
  localparam int DIV_WIDTH = 16;

  // Width of the settle counter; SETTLE_CYCLES is limited to 1..15.
  localparam int DIV_CNT_W = 4;

  // Quotient reported on divide-by-zero (all ones).
  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = '1;

  // Most negative signed value; the only dividend whose signed quotient can
  // overflow (when divided by -1).
  localparam logic [DIV_WIDTH-1:0] DIV_SMIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // All-ones divisor, i.e. -1 when the operands are signed.
  localparam logic [DIV_WIDTH-1:0] DIV_NEG_ONE = '1;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negate
//
// Purpose : y = neg ? -a : a, WIDTH-bit two's complement with the carry out
//           discarded. Used both to turn signed operands into magnitudes and
//           to put the sign back onto the unsigned divider results.
// Ports   :
//   neg  in  1      negate when 1
//   a    in  WIDTH  operand
//   y    out WIDTH  result
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] one;
  logic [WIDTH-1:0] negated;

  assign one     = {{(WIDTH-1){1'b0}}, 1'b1};
  assign negated = (~a) + one;
  assign y       = neg ? negated : a;

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - issue/retire controller around the combinational array divider
//
// Purpose : Accepts signed/unsigned divide requests, feeds operand magnitudes
//           to the ripple divider array from registers, waits SETTLE_CYCLES
//           for the array to resolve, then captures and sign-corrects the
//           quotient/remainder. Divide-by-zero and signed MIN/-1 are resolved
//           on accept without touching the divider.
// Config  : define DIV_SMALL_SHORTCUT_EN to also retire |dividend| < |divisor|
//           requests on accept (quotient 0, remainder = dividend).
// Ports   :
//   clk           in  1      clock
//   rst_n         in  1      asynchronous active-low reset
//   req_valid     in  1      request present
//   req_ready     out 1      controller idle, can accept
//   req_dividend  in  WIDTH  dividend
//   req_divisor   in  WIDTH  divisor
//   req_signed    in  1      1 = two's-complement operands
//   div_q_o       out WIDTH  dividend magnitude to divider Q input
//   div_m_o       out WIDTH  divisor magnitude to divider M input
//   div_quo_i     in  WIDTH  divider quotient (unsigned)
//   div_rem_i     in  WIDTH  divider remainder (unsigned, corrected)
//   rsp_valid     out 1      result present
//   rsp_ready     in  1      consumer accepts result
//   rsp_quo       out WIDTH  final quotient
//   rsp_rem       out WIDTH  final remainder
//   rsp_dbz       out 1      divide-by-zero flag
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic             req_signed,
  output logic [WIDTH-1:0] div_q_o,
  output logic [WIDTH-1:0] div_m_o,
  input  logic [WIDTH-1:0] div_quo_i,
  input  logic [WIDTH-1:0] div_rem_i,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quo,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_dbz
);

  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(SETTLE_CYCLES - 1);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 sign_q;   // result remainder takes the dividend's sign
  logic                 sign_r;   // quotient is negative when operand signs differ

  logic                 dvd_neg;
  logic                 dvs_neg;
  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  logic                 is_dbz;
  logic                 is_ovf;
  logic                 accept;

  assign dvd_neg = req_signed & req_dividend[WIDTH-1];
  assign dvs_neg = req_signed & req_divisor[WIDTH-1];

  // Operand magnitudes presented to the divider. For the signed minimum the
  // negation wraps back to itself, which is the correct unsigned magnitude.
  div_sign_fix #(.WIDTH(WIDTH)) u_dvd_mag (
    .neg (dvd_neg),
    .a   (req_dividend),
    .y   (dvd_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_dvs_mag (
    .neg (dvs_neg),
    .a   (req_divisor),
    .y   (dvs_mag)
  );

  // Sign restoration of the unsigned divider outputs.
  div_sign_fix #(.WIDTH(WIDTH)) u_quo_fix (
    .neg (sign_r),
    .a   (div_quo_i),
    .y   (quo_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
    .neg (sign_q),
    .a   (div_rem_i),
    .y   (rem_fix)
  );

  assign is_dbz = (req_divisor == '0);
  assign is_ovf = req_signed && (req_dividend == DIV_SMIN) && (req_divisor == DIV_NEG_ONE);
  assign accept = (state == ST_IDLE) && req_valid;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      div_q_o <= '0;
      div_m_o <= '0;
      rsp_quo <= '0;
      rsp_rem <= '0;
      rsp_dbz <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sign_q <= dvd_neg;
            sign_r <= dvd_neg ^ dvs_neg;
            if (is_dbz) begin
              rsp_quo <= DIV_DBZ_QUO;
              rsp_rem <= req_dividend;
              rsp_dbz <= 1'b1;
              state   <= ST_DONE;
            end else if (is_ovf) begin
              // MIN / -1 has no representable positive quotient; the wrapped
              // value MIN is returned with a zero remainder.
              rsp_quo <= DIV_SMIN;
              rsp_rem <= '0;
              rsp_dbz <= 1'b0;
              state   <= ST_DONE;
`ifdef DIV_SMALL_SHORTCUT_EN
            end else if (dvd_mag < dvs_mag) begin
              // Quotient is trivially zero and the remainder is the dividend
              // itself, sign included; no need to wait on the array.
              rsp_quo <= '0;
              rsp_rem <= req_dividend;
              rsp_dbz <= 1'b0;
              state   <= ST_DONE;
`endif
            end else begin
              div_q_o <= dvd_mag;
              div_m_o <= dvs_mag;
              cnt     <= CNT_LOAD;
              state   <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          // Capture happens on the cycle after the counter reaches zero, so
          // the divider inputs have been stable for SETTLE_CYCLES full cycles.
          if (cnt == '0) begin
            rsp_quo <= quo_fix;
            rsp_rem <= rem_fix;
            rsp_dbz <= 1'b0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

  localparam int W      = 16;
  localparam int SETTLE = 4;
`ifdef DIV_SMALL_SHORTCUT_EN
  localparam bit SHORT = 1'b1;
`else
  localparam bit SHORT = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_dividend;
  logic [W-1:0] req_divisor;
  logic         req_signed;
  logic [W-1:0] div_q_o;
  logic [W-1:0] div_m_o;
  logic [W-1:0] div_quo_i;
  logic [W-1:0] div_rem_i;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_quo;
  logic [W-1:0] rsp_rem;
  logic         rsp_dbz;

  int checks = 0;
  int errors = 0;

  // Expected divider inputs: whatever the last normal-path accept loaded.
  logic [W-1:0] exp_q_in;
  logic [W-1:0] exp_m_in;

  div_seq_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_signed   (req_signed),
    .div_q_o      (div_q_o),
    .div_m_o      (div_m_o),
    .div_quo_i    (div_quo_i),
    .div_rem_i    (div_rem_i),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quo      (rsp_quo),
    .rsp_rem      (rsp_rem),
    .rsp_dbz      (rsp_dbz)
  );

  // Behavioural stand-in for the combinational divider array.
  assign div_quo_i = (div_m_o == '0) ? '1 : div_q_o / div_m_o;
  assign div_rem_i = (div_m_o == '0) ? div_q_o : div_q_o % div_m_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         sgn;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    int           lat;
    int           hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic rules: truncating division on the
  // integer values of the operands, result wrapped to W bits.
  task automatic ref_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                         output logic [W-1:0] quo, output logic [W-1:0] rem, output logic dbz,
                         output int lat, output logic [W-1:0] mag_d, output logic [W-1:0] mag_s);
    int a, b, q, r, abs_a, abs_b;
    a = sgn ? int'($signed(dvd)) : int'(dvd);
    b = sgn ? int'($signed(dvs)) : int'(dvs);
    abs_a = (a < 0) ? -a : a;
    abs_b = (b < 0) ? -b : b;
    mag_d = W'(abs_a);
    mag_s = W'(abs_b);
    if (b == 0) begin
      quo = '1; rem = dvd; dbz = 1'b1; lat = 1;
    end else begin
      q = a / b;
      r = a % b;
      quo = W'(q); rem = W'(r); dbz = 1'b0;
      if (sgn && a == -32768 && b == -1) lat = 1;
      else if (SHORT && abs_a < abs_b) lat = 1;
      else lat = SETTLE + 1;
    end
  endtask

  // Issue one request, measure latency, check result, hold backpressure for
  // `hold` cycles, then retire.
  task automatic run_req(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic sgn, input logic [W-1:0] equo, input logic [W-1:0] erem,
                         input logic edbz, input int elat, input int hold);
    int lat, guard;
    logic [W-1:0] mq, mr, md, ms;
    logic         mdbz;
    int           mlat;
    ref_div(dvd, dvs, sgn, mq, mr, mdbz, mlat, md, ms);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, " req_ready_before"}, 32'(req_ready), 32'd1);
    req_dividend = dvd; req_divisor = dvs; req_signed = sgn; req_valid = 1'b1;
    @(posedge clk); lat = 1; #1;
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (!rsp_valid) return;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " quo"}, 32'(rsp_quo), 32'(equo));
    chk({tag, " rem"}, 32'(rsp_rem), 32'(erem));
    chk({tag, " dbz"}, 32'(rsp_dbz), 32'(edbz));
    if (mlat != 1) begin
      exp_q_in = md;
      exp_m_in = ms;
    end
    chk({tag, " div_q_o"}, 32'(div_q_o), 32'(exp_q_in));
    chk({tag, " div_m_o"}, 32'(div_m_o), 32'(exp_m_in));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " held_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " held_quo"}, 32'(rsp_quo), 32'(equo));
      chk({tag, " held_rem"}, 32'(rsp_rem), 32'(erem));
      chk({tag, " held_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " retired"}, 32'(rsp_valid), 32'd0);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] dvd, dvs, q, r, md, ms;
    logic         sgn, dbz;
    int           lat;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_dividend = '0; req_divisor = '0; req_signed = 1'b0;
    exp_q_in = '0; exp_m_in = '0;

    vecs.push_back('{16'd13869, 16'd900,  1'b0, 16'd15,     16'd369,   1'b0, SETTLE + 1, 0});
    vecs.push_back('{16'hFFF9,  16'h0002, 1'b1, 16'hFFFD,   16'hFFFF,  1'b0, SETTLE + 1, 0});
    vecs.push_back('{16'd40000, 16'd12000,1'b0, 16'd3,      16'd4000,  1'b0, SETTLE + 1, 1});
    vecs.push_back('{16'd1234,  16'd0,    1'b0, 16'hFFFF,   16'd1234,  1'b1, 1,          0});
    vecs.push_back('{16'h8000,  16'hFFFF, 1'b1, 16'h8000,   16'h0000,  1'b0, 1,          0});
    vecs.push_back('{16'd9801,  16'd310,  1'b0, 16'd31,     16'd191,   1'b0, SETTLE + 1, 5});
    vecs.push_back('{16'd21,    16'd300,  1'b0, 16'd0,      16'd21,    1'b0, SHORT ? 1 : SETTLE + 1, 0});
    vecs.push_back('{16'h8000,  16'hFFFF, 1'b0, 16'd0,      16'h8000,  1'b0, SHORT ? 1 : SETTLE + 1, 0});
    vecs.push_back('{16'hFFF9,  16'd300,  1'b1, 16'd0,      16'hFFF9,  1'b0, SHORT ? 1 : SETTLE + 1, 0});

    #12;
    chk("reset req_ready_low", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_quo", 32'(rsp_quo), 32'd0);
    chk("reset rsp_rem", 32'(rsp_rem), 32'd0);
    chk("reset rsp_dbz", 32'(rsp_dbz), 32'd0);
    chk("reset div_q_o", 32'(div_q_o), 32'd0);
    chk("reset div_m_o", 32'(div_m_o), 32'd0);

    foreach (vecs[i])
      run_req($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].sgn,
              vecs[i].quo, vecs[i].rem, vecs[i].dbz, vecs[i].lat, vecs[i].hold);

    // Reset in the middle of SETTLE aborts the operation.
    req_dividend = 16'd13869; req_divisor = 16'd900; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst div_q_o", 32'(div_q_o), 32'd0);
    chk("midrst div_m_o", 32'(div_m_o), 32'd0);
    chk("midrst rsp_quo", 32'(rsp_quo), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q_in = '0; exp_m_in = '0;
    for (int c = 0; c < SETTLE + 2; c++) begin
      @(posedge clk); #1;
      chk("midrst no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_req("after_rst", 16'd15, 16'd3, 1'b0, 16'd5, 16'd0, 1'b0, SETTLE + 1, 0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0: dvs = '0;
        1: dvs = W'($urandom_range(1, 20));
        2: dvs = 16'hFFFF;
        default: dvs = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: dvd = 16'h8000;
        1: dvd = W'($urandom_range(0, 40));
        default: dvd = W'($urandom);
      endcase
      sgn = 1'($urandom);
      ref_div(dvd, dvs, sgn, q, r, dbz, lat, md, ms);
      run_req($sformatf("rnd%0d", n), dvd, dvs, sgn, q, r, dbz, lat, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
